// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Program-memory read bus used by the instruction fetch unit.
//            A request is held (mem_req/mem_addr stable) until mem_ack is
//            returned; mem_rdata is valid in the cycle of mem_ack.
// Signals  : mem_req   - read request (driven by master)
//            mem_addr  - byte address of the read (driven by master)
//            mem_ack   - request accepted, data valid (driven by slave)
//            mem_rdata - 16-bit read data (driven by slave)
// Modports : master - fetch unit side; slave - program memory side
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch unit. Owns the program counter, fetches 16-bit
//            words from program memory over a req/ack bus into a small
//            prefetch FIFO and presents the head word to the control unit.
//            Consume requests advance the stream; branches flush the FIFO and
//            redirect fetching.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            pc_inc       - consume head word as an instruction
//            en_pc_2      - consume head word as an extension word
//            branch_en    - jump relative to the head word
//            pc_offset    - signed 10-bit word offset of the jump
//            instruction  - head word of the FIFO (0 when not valid)
//            inst_valid   - instruction/inst_pc valid
//            inst_pc      - byte address of the head word (0 when not valid)
//            fsm_state    - 00 IDLE, 01 REQ, 10 DISCARD
//            mem          - program memory bus (master side)
// Params   : RESET_PC   - first fetch address after reset (bit 0 must be 0)
//            FIFO_DEPTH - prefetch entries, 2 or 4
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        pc_inc,
  input  wire logic        en_pc_2,
  input  wire logic        branch_en,
  input  wire logic [9:0]  pc_offset,
  output logic [15:0]      instruction,
  output logic             inst_valid,
  output logic [15:0]      inst_pc,
  output logic [1:0]       fsm_state,
  fetch_unit_if.master     mem
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_REQ     = 2'b01;
  localparam logic [1:0] S_DISCARD = 2'b10;

  logic [1:0]       state, state_nxt;
  logic             issue;
  logic [15:0]      fetch_ptr;
  logic [15:0]      fifo_data [FIFO_DEPTH];
  logic [15:0]      fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_nxt;

  logic        ack, valid, take_branch, pop, push, space;
  logic [15:0] head_pc, target;

  // An ack only means something while a request is actually on the bus.
  assign ack         = mem.mem_req & mem.mem_ack;
  assign valid       = (count != '0);
  assign take_branch = branch_en & valid;
  // The jump word is consumed by the branch itself, so a branch masks pop.
  assign pop         = (pc_inc | en_pc_2) & valid & ~take_branch;
  // Data returned in DISCARD, or alongside a branch, belongs to the old stream.
  assign push        = ack & (state == S_REQ) & ~take_branch;
  assign count_nxt   = take_branch ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
  // Room for one more outstanding request once this cycle's push/pop settle.
  assign space       = (count_nxt < DEPTH_C);

  assign head_pc = fifo_pc[rd_ptr];
  assign target  = head_pc + 16'd2 + {{5{pc_offset[9]}}, pc_offset, 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        // Hold off issuing in a branch cycle: fetch_ptr is about to change.
        if (!take_branch && space) begin
          state_nxt = S_REQ;
          issue     = 1'b1;
        end
      end
      S_REQ: begin
        if (take_branch) begin
          // Without the ack the request must still be held to completion.
          state_nxt = ack ? S_IDLE : S_DISCARD;
        end else if (ack) begin
          if (space) begin
            state_nxt = S_REQ;
            issue     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs (all derived from registered state)
  always_comb begin
    mem.mem_req = (state != S_IDLE);
    fsm_state   = state;
    inst_valid  = valid;
    instruction = valid ? fifo_data[rd_ptr] : 16'h0000;
    inst_pc     = valid ? head_pc : 16'h0000;
  end

  // Program counter, request address and FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr    <= RESET_PC;
      mem.mem_addr <= 16'h0000;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      if (take_branch)  fetch_ptr <= target;
      else if (push)    fetch_ptr <= fetch_ptr + 16'd2;

      // In REQ fetch_ptr equals the outstanding address, so a back-to-back
      // re-issue targets the following word.
      if (issue) mem.mem_addr <= (state == S_IDLE) ? fetch_ptr : (fetch_ptr + 16'd2);

      if (take_branch) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem.mem_rdata;
      fifo_pc[wr_ptr]   <= mem.mem_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Program memory returns the
//            bitwise inverse of the address; ack latency is selectable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 1: RESET_PC C000, depth 2, programmable-latency memory
  logic        pc_inc = 1'b0, en_pc_2 = 1'b0, branch_en = 1'b0;
  logic [9:0]  pc_offset = 10'h000;
  logic [15:0] instruction, inst_pc;
  logic        inst_valid;
  logic [1:0]  fsm_state;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'hC000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .en_pc_2(en_pc_2),
    .branch_en(branch_en), .pc_offset(pc_offset), .instruction(instruction),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .fsm_state(fsm_state), .mem(bus)
  );

  int   ack_delay = 0;
  int   wcnt = 0;
  logic force_ack = 1'b0;
  always_comb bus.mem_ack = force_ack | (bus.mem_req && (wcnt == ack_delay));
  assign bus.mem_rdata = ~bus.mem_addr;
  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
  end

  // DUT 2: RESET_PC FFFE, depth 4, zero-wait memory (address wrap)
  logic        pop2 = 1'b0;
  logic [15:0] instruction2, inst_pc2;
  logic        inst_valid2;
  logic [1:0]  fsm_state2;
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .pc_inc(pop2), .en_pc_2(1'b0),
    .branch_en(1'b0), .pc_offset(10'h000), .instruction(instruction2),
    .inst_valid(inst_valid2), .inst_pc(inst_pc2), .fsm_state(fsm_state2), .mem(bus2)
  );

  assign bus2.mem_ack   = bus2.mem_req;
  assign bus2.mem_rdata = ~bus2.mem_addr;
  logic [15:0] log2 [$];
  always @(posedge clk) if (bus2.mem_req && bus2.mem_ack) log2.push_back(bus2.mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        pc_inc, en_pc_2, branch_en;
    logic [9:0]  off;
    logic        valid;
    logic [15:0] instr, pc;
    logic        req;
    logic [15:0] addr;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n;
    logic [15:0] exp2 [4];

    // Zero-wait memory; each row shows the state after the clock edge.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hC000, 2'b01};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FFF, 16'hC000, 1'b1, 16'hC002, 2'b01};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FFF, 16'hC000, 1'b0, 16'hC002, 2'b00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FFF, 16'hC000, 1'b0, 16'hC002, 2'b00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FFD, 16'hC002, 1'b1, 16'hC004, 2'b01};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FFD, 16'hC002, 1'b0, 16'hC004, 2'b00};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 10'h000, 1'b1, 16'h3FFB, 16'hC004, 1'b1, 16'hC006, 2'b01};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 10'h003, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hC006, 2'b00};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hC00C, 2'b01};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FF3, 16'hC00C, 1'b1, 16'hC00E, 2'b01};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'h3FF3, 16'hC00C, 1'b0, 16'hC00E, 2'b00};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", {15'd0, inst_valid}, 16'd0);
    chk("rst_req",   {15'd0, bus.mem_req}, 16'd0);
    chk("rst_state", {14'd0, fsm_state}, 16'd0);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_pc",    inst_pc, 16'h0000);
    rst = 1'b0;

    // Fill, backpressure, dual pop, forward branch, ignored pop/branch
    for (int i = 0; i < 11; i++) begin
      pc_inc    = tbl[i].pc_inc;
      en_pc_2   = tbl[i].en_pc_2;
      branch_en = tbl[i].branch_en;
      pc_offset = tbl[i].off;
      step();
      chk($sformatf("v%0d_valid", i), {15'd0, inst_valid}, {15'd0, tbl[i].valid});
      chk($sformatf("v%0d_instr", i), instruction, tbl[i].instr);
      chk($sformatf("v%0d_pc", i),    inst_pc, tbl[i].pc);
      chk($sformatf("v%0d_req", i),   {15'd0, bus.mem_req}, {15'd0, tbl[i].req});
      chk($sformatf("v%0d_addr", i),  bus.mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_state", i), {14'd0, fsm_state}, {14'd0, tbl[i].st});
    end
    pc_inc = 1'b0; en_pc_2 = 1'b0; branch_en = 1'b0; pc_offset = 10'h000;

    // Branch C00C -> C010, then a self-loop at C010 five times
    pc_offset = 10'h001; branch_en = 1'b1;
    step();
    branch_en = 1'b0;
    for (int it = 0; it < 5; it++) begin
      n = 0;
      while (!bus.mem_req && n < 20) begin step(); n++; end
      chk($sformatf("loop%0d_req_timeout", it), {15'd0, (n < 20)}, 16'd1);
      chk($sformatf("loop%0d_addr", it), bus.mem_addr, 16'hC010);
      n = 0;
      while (!inst_valid && n < 20) begin step(); n++; end
      chk($sformatf("loop%0d_valid_timeout", it), {15'd0, (n < 20)}, 16'd1);
      chk($sformatf("loop%0d_pc", it), inst_pc, 16'hC010);
      chk($sformatf("loop%0d_instr", it), instruction, 16'h3FEF);
      pc_offset = 10'h3FF; branch_en = 1'b1;
      step();
      branch_en = 1'b0;
    end

    // Address wrap FFFE -> 0000 on the depth-4 instance (full, never popped)
    exp2[0] = 16'hFFFE; exp2[1] = 16'h0000; exp2[2] = 16'h0002; exp2[3] = 16'h0004;
    chk("wrap_nreq", 16'(log2.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log2.size()) chk($sformatf("wrap_req%0d", i), log2[i], exp2[i]);
      chk($sformatf("wrap_pc%0d", i), inst_pc2, exp2[i]);
      chk($sformatf("wrap_instr%0d", i), instruction2, ~exp2[i]);
      pop2 = 1'b1;
      step();
      pop2 = 1'b0;
    end

    // Branch while a slow (3-cycle) request is outstanding
    ack_delay = 3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("slow_first_req", {15'd0, bus.mem_req}, 16'd1);
    chk("slow_first_addr", bus.mem_addr, 16'hC000);
    n = 0;
    while (!inst_valid && n < 20) begin step(); n++; end
    chk("slow_valid_timeout", {15'd0, (n < 20)}, 16'd1);
    chk("slow_state_req", {14'd0, fsm_state}, 16'd1);
    chk("slow_addr2", bus.mem_addr, 16'hC002);
    chk("slow_head_pc", inst_pc, 16'hC000);
    pc_offset = 10'h005; branch_en = 1'b1;
    step();
    branch_en = 1'b0;
    n = 0;
    while (fsm_state == 2'b10 && n < 20) begin
      chk("disc_req", {15'd0, bus.mem_req}, 16'd1);
      chk("disc_addr", bus.mem_addr, 16'hC002);
      chk("disc_valid", {15'd0, inst_valid}, 16'd0);
      chk("disc_instr", instruction, 16'h0000);
      step();
      n++;
    end
    chk("disc_cycles", 16'(n), 16'd3);
    chk("disc_to_idle", {14'd0, fsm_state}, 16'd0);
    chk("disc_idle_req", {15'd0, bus.mem_req}, 16'd0);
    step();
    chk("redirect_state", {14'd0, fsm_state}, 16'd1);
    chk("redirect_addr", bus.mem_addr, 16'hC00C);
    chk("redirect_valid", {15'd0, inst_valid}, 16'd0);

    // Reset during an outstanding request, followed by a late ack
    step();
    rst = 1'b1;
    step();
    chk("midrst_req", {15'd0, bus.mem_req}, 16'd0);
    chk("midrst_state", {14'd0, fsm_state}, 16'd0);
    chk("midrst_valid", {15'd0, inst_valid}, 16'd0);
    rst = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("lateack_valid", {15'd0, inst_valid}, 16'd0);
    chk("restart_req", {15'd0, bus.mem_req}, 16'd1);
    chk("restart_addr", bus.mem_addr, 16'hC000);
    n = 0;
    while (!inst_valid && n < 20) begin step(); n++; end
    chk("restart_timeout", {15'd0, (n < 20)}, 16'd1);
    chk("restart_pc", inst_pc, 16'hC000);
    chk("restart_instr", instruction, 16'h3FFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
